// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with architectural HI/LO
// registers, sitting in the E stage. A single operation is in flight at a
// time. Its result is computed from the operands captured on the start edge
// and is committed to HI/LO when the busy countdown expires.
//
// Optional build macro: MDU_CANCEL_EN
//   When defined, the unit gains a Req input (exception/interrupt request at
//   M). Req suppresses new starts and mthi/mtlo writes, but it does not abort
//   an operation that is already in flight.
//   When undefined, Req is absent and the unit behaves as if Req were 0.

module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MDU_CANCEL_EN
  input  logic        Req,
`endif
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  // Operation encodings produced by the decoder
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // The counter must hold the longer of the two latencies
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Signed 32x32 -> 64 product; operands are sign-extended to full width first
  function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  // Unsigned 32x32 -> 64 product
  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua;
    logic [63:0] ub;
    ua = {32'h0000_0000, a};
    ub = {32'h0000_0000, b};
    return ua * ub;
  endfunction

  // Unsigned divide, packed as {remainder, quotient}; caller screens b == 0
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    q = a / b;
    r = a % b;
    return {r, q};
  endfunction

  // Signed divide via magnitudes: quotient truncates toward zero and the
  // remainder takes the sign of the dividend. The magnitude of 0x80000000 is
  // still representable as an unsigned 32-bit value, so the overflow case
  // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q;
    logic [31:0] r;
    mag_a = a[31] ? (32'd0 - a) : a;
    mag_b = b[31] ? (32'd0 - b) : b;
    q_mag = mag_a / mag_b;
    r_mag = mag_a % mag_b;
    q     = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
    r     = a[31] ? (32'd0 - r_mag) : r_mag;
    return {r, q};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_r;
  logic             busy_r;
  logic [CNT_W-1:0] cnt_r;
  logic [63:0]      pending_r;
  logic             pending_wr_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic             cancel_s;
  logic             is_md_s;
  logic             is_mult_s;
  logic             start_s;
  logic             mt_ok_s;
  logic [63:0]      calc_s;
  logic             calc_wr_s;
  logic [CNT_W-1:0] load_s;
  logic [31:0]      out_s;

`ifdef MDU_CANCEL_EN
  assign cancel_s = Req;
`else
  assign cancel_s = 1'b0;
`endif

  // Classify the incoming op and decide whether a new operation starts
  always_comb begin
    is_md_s   = 1'b0;
    is_mult_s = 1'b0;
    case (MDUOp)
      OP_MULT, OP_MULTU: begin
        is_md_s   = 1'b1;
        is_mult_s = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        is_md_s   = 1'b1;
        is_mult_s = 1'b0;
      end
      default: begin
        is_md_s   = 1'b0;
        is_mult_s = 1'b0;
      end
    endcase
    if (is_md_s && !busy_r && !cancel_s) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
    if (!busy_r && !cancel_s) begin
      mt_ok_s = 1'b1;
    end else begin
      mt_ok_s = 1'b0;
    end
    if (is_mult_s) begin
      load_s = MULT_LOAD;
    end else begin
      load_s = DIV_LOAD;
    end
  end

  // Compute the result to be held pending; a zero divisor leaves HI/LO untouched
  always_comb begin
    calc_s    = 64'h0;
    calc_wr_s = 1'b0;
    case (MDUOp)
      OP_MULT: begin
        calc_s    = mul_signed(A, B);
        calc_wr_s = 1'b1;
      end
      OP_MULTU: begin
        calc_s    = mul_unsigned(A, B);
        calc_wr_s = 1'b1;
      end
      OP_DIV: begin
        if (B != 32'h0000_0000) begin
          calc_s    = div_signed(A, B);
          calc_wr_s = 1'b1;
        end else begin
          calc_s    = 64'h0;
          calc_wr_s = 1'b0;
        end
      end
      OP_DIVU: begin
        if (B != 32'h0000_0000) begin
          calc_s    = div_unsigned(A, B);
          calc_wr_s = 1'b1;
        end else begin
          calc_s    = 64'h0;
          calc_wr_s = 1'b0;
        end
      end
      default: begin
        calc_s    = 64'h0;
        calc_wr_s = 1'b0;
      end
    endcase
  end

  // Read port: mfhi/mflo return the current (possibly stale while busy) value
  always_comb begin
    case (MDUOp)
      OP_MFHI: out_s = hi_r;
      OP_MFLO: out_s = lo_r;
      OP_NONE: out_s = 32'h0000_0000;
      default: out_s = 32'h0000_0000;
    endcase
  end

  // Control FSM: start/countdown/commit plus mthi/mtlo writes while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      cnt_r        <= CNT_ZERO;
      pending_r    <= 64'h0;
      pending_wr_r <= 1'b0;
      hi_r         <= 32'h0000_0000;
      lo_r         <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r      <= ST_RUN;
            busy_r       <= 1'b1;
            cnt_r        <= load_s;
            pending_r    <= calc_s;
            pending_wr_r <= calc_wr_s;
          end else if (mt_ok_s && (MDUOp == OP_MTHI)) begin
            hi_r <= A;
          end else if (mt_ok_s && (MDUOp == OP_MTLO)) begin
            lo_r <= A;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
            if (pending_wr_r) begin
              hi_r <= pending_r[63:32];
              lo_r <= pending_r[31:0];
            end else begin
              hi_r <= hi_r;
              lo_r <= lo_r;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign Start = start_s;
  assign Busy  = busy_r;
  assign HI    = hi_r;
  assign LO    = lo_r;
  assign Out   = out_s;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo. Expected HI/LO pairs are produced by a
// behavioural model when an operation is issued, queued, and compared when
// the unit finishes (Busy falls).
module tb_mdu_hilo;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
`ifdef MDU_CANCEL_EN
  logic        Req;
`endif
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .MDUOp (MDUOp),
    .A     (A),
    .B     (B),
`ifdef MDU_CANCEL_EN
    .Req   (Req),
`endif
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO),
    .Out   (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: 64-bit arithmetic, {hi,lo}; cur returned when no write
  function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    p = cur;
    case (op)
      4'd1: begin sa = $signed(a); sb = $signed(b); p = sa * sb; end
      4'd2: p = {32'h0, a} * {32'h0, b};
      4'd3: if (b != 32'h0) begin
              sa = $signed(a); sb = $signed(b); q = sa / sb; r = sa % sb;
              p = {r[31:0], q[31:0]};
            end
      4'd4: if (b != 32'h0) p = {a % b, a / b};
      default: p = cur;
    endcase
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start, push the model's expectation, and step into busy cycle 1
  task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    sb_q.push_back(model_result(op, a, b, {model_hi, model_lo}));
    MDUOp = op; A = a; B = b;
    #1;
    checks++;
    if (Start !== 1'b1) begin errors++; $display("FAIL start_op%0d: Start=%b want 1", op, Start); end
    tick();
    MDUOp = 4'd0; A = $urandom; B = $urandom;
  endtask

  // Count remaining busy cycles, then pop the scoreboard and compare HI/LO
  task automatic wait_commit(input string name, input int exp_cycles);
    int n;
    logic [63:0] exp;
    n = 0;
    while (Busy === 1'b1 && n < 200) begin n++; tick(); end
    checks++;
    if (n != exp_cycles) begin errors++; $display("FAIL %s_busy: cycles=%0d want %0d", name, n, exp_cycles); end
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL %s_sb: queue empty want 1 entry", name);
    end else begin
      exp = sb_q.pop_front();
      if ({HI, LO} !== exp) begin errors++; $display("FAIL %s_hilo: got %h want %h", name, {HI, LO}, exp); end
      model_hi = exp[63:32];
      model_lo = exp[31:0];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; MDUOp = 4'd0; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    tick(); tick();
    reset = 1'b0;
    #1;
    model_hi = 32'h0; model_lo = 32'h0;
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", Start); end
    checks++; if (Out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 0", Out); end
  endtask

  task automatic test_mult();
    issue_op(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_commit("mult", MULT_N);
    checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_const: got %h_%h want ffffffff_fffffffa", HI, LO); end
    issue_op(4'd2, 32'hFFFF_FFFE, 32'd3);
    wait_commit("multu", MULT_N);
    checks++; if (HI !== 32'h0000_0002 || LO !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL multu_const: got %h_%h want 00000002_fffffffa", HI, LO); end
    for (int i = 0; i < 4; i++) begin
      issue_op((i % 2 == 0) ? 4'd1 : 4'd2, $urandom, $urandom);
      wait_commit("mult_rand", MULT_N);
    end
  endtask

  task automatic test_div();
    issue_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_commit("div", DIV_N);
    checks++; if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_const: got hi=%h lo=%h want ffffffff fffffffd", HI, LO); end
    issue_op(4'd4, 32'd7, 32'd0);
    wait_commit("divu_zero", DIV_N);
    checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL divu_zero_keep: got %h_%h want ffffffff_fffffffd", HI, LO); end
    issue_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_commit("div_ovf", DIV_N);
    checks++; if (LO !== 32'h8000_0000 || HI !== 32'h0) begin
      errors++; $display("FAIL div_ovf_const: got hi=%h lo=%h want 0 80000000", HI, LO); end
    issue_op(4'd4, 32'hFFFF_FFF9, 32'd10);
    wait_commit("divu", DIV_N);
    issue_op(4'd3, 32'd100, 32'hFFFF_FFF9);
    wait_commit("div_negdiv", DIV_N);
  endtask

  task automatic test_mt_mf();
    MDUOp = 4'd8; A = 32'h1234_5678;
    tick();
    model_lo = 32'h1234_5678;
    MDUOp = 4'd6; A = 32'h0;
    #1;
    checks++; if (Out !== 32'h1234_5678) begin errors++; $display("FAIL mflo: got %h want 12345678", Out); end
    MDUOp = 4'd7; A = 32'hCAFE_F00D;
    tick();
    model_hi = 32'hCAFE_F00D;
    MDUOp = 4'd5;
    #1;
    checks++; if (Out !== 32'hCAFE_F00D) begin errors++; $display("FAIL mfhi: got %h want cafef00d", Out); end
    MDUOp = 4'd9;
    #1;
    checks++; if (Out !== 32'h0 || Start !== 1'b0) begin
      errors++; $display("FAIL op9: Out=%h Start=%b want 0 0", Out, Start); end
    MDUOp = 4'd0;
  endtask

  task automatic test_busy_collisions();
    issue_op(4'd1, 32'h0001_0003, 32'h0000_0007);
    MDUOp = 4'd7; A = 32'hDEAD_BEEF;
    tick();
    checks++; if (HI !== model_hi) begin errors++; $display("FAIL mthi_busy: got %h want %h", HI, model_hi); end
    MDUOp = 4'd5;
    #1;
    checks++; if (Out !== model_hi) begin errors++; $display("FAIL mfhi_busy: got %h want %h", Out, model_hi); end
    MDUOp = 4'd0;
    wait_commit("mthi_busy", MULT_N - 1);
    issue_op(4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    MDUOp = 4'd1; A = 32'd5; B = 32'd9;
    #1;
    checks++; if (Start !== 1'b0) begin errors++; $display("FAIL start_busy: got %b want 0", Start); end
    tick();
    MDUOp = 4'd0;
    wait_commit("no_restart", MULT_N - 1);
  endtask

  task automatic test_reset_mid();
    int bad;
    issue_op(4'd3, 32'h0000_0064, 32'd7);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    model_hi = 32'h0; model_lo = 32'h0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", Busy); end
    checks++; if (HI !== 32'h0 || LO !== 32'h0) begin
      errors++; $display("FAIL rst_mid_hilo: got %h_%h want 0_0", HI, LO); end
    bad = 0;
    for (int i = 0; i < DIV_N + 2; i++) begin
      if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_nocommit: bad cycles=%0d want 0", bad); end
  endtask

`ifdef MDU_CANCEL_EN
  task automatic test_cancel();
    Req = 1'b1; MDUOp = 4'd1; A = 32'd3; B = 32'd4;
    #1;
    checks++; if (Start !== 1'b0) begin errors++; $display("FAIL cancel_start: got %b want 0", Start); end
    tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", Busy); end
    MDUOp = 4'd7; A = 32'h5555_AAAA;
    tick();
    checks++; if (HI !== model_hi) begin errors++; $display("FAIL cancel_mthi: got %h want %h", HI, model_hi); end
    Req = 1'b0; MDUOp = 4'd0;
    issue_op(4'd2, 32'd6, 32'd7);
    Req = 1'b1;
    tick();
    Req = 1'b0;
    wait_commit("cancel_inflight", MULT_N - 1);
  endtask
`endif

  initial begin
`ifdef MDU_CANCEL_EN
    Req = 1'b0;
`endif
    test_reset();
    test_mult();
    test_div();
    test_mt_mf();
    test_busy_collisions();
    test_reset_mid();
`ifdef MDU_CANCEL_EN
    test_cancel();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers. Lives in the E stage, directly downstream of the decoder.
- Consumes the decoder's 4-bit MDUOp and the forwarded rs/rt operands.
- Produces mfhi/mflo read data and Start/Busy for the hazard unit, which stalls MD-class instructions in D while the unit is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu after the start cycle (>=1)
DIV_CYCLES, 10, busy cycles for div/divu after the start cycle (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none
A  input  32  rs operand, forwarded
B  input  32  rt operand, forwarded
Req  input  1  present only with MDU_CANCEL_EN; see Optional Feature
Start  output  1  combinational; 1 when MDUOp in {1..4}, Busy=0 and no cancel is active
Busy  output  1  registered; 1 while an operation is in flight
HI  output  32  current HI register
LO  output  32  current LO register
Out  output  32  combinational; HI if MDUOp=5, LO if MDUOp=6, else 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: HI=0, LO=0, Busy=0, counter=0, pending result=0. Reset mid-operation aborts the operation with no HI/LO commit. Reset has priority over every other event.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, counter>0.
- IDLE -> RUN: on an edge with Start=1.
  - Latch pending {hi,lo} computed from A,B in that cycle.
  - counter <= MULT_CYCLES for ops 1/2; counter <= DIV_CYCLES for ops 3/4.
- RUN: each edge decrements counter.
- RUN -> IDLE: on the edge where counter==1.
  - HI/LO <= pending.
  - Busy <= 0.
  - The new values are visible in the next cycle.
- Busy timing: Busy is high for exactly N cycles following the start cycle.
- Results: operands are captured at start, so later changes on A/B have no effect.
  - mult: {HI,LO} = signed A * signed B, 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, same sign as dividend A.
  - divu: unsigned quotient and remainder.
- Boundary conditions for division:
  - B=0 on div/divu: the op still occupies the unit for DIV_CYCLES; HI/LO are left unchanged at commit.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo when Busy=0: HI (or LO) <= A on that edge. When Busy=1 they are ignored; the hazard unit is required to prevent this.
- MDUOp 1..4 with Busy=1: ignored. Start=0 and the in-flight op is unaffected.
- mfhi/mflo while Busy=1: Out returns the old HI/LO. The hazard unit must stall these in D, using Start|Busy as the stall term.
- Same-edge collision: an mthi/mtlo edge and a commit edge cannot coincide, because mthi/mtlo require Busy=0.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- When defined, input Req (exception/interrupt request at M) is added.
  - Req=1 forces Start=0.
  - mthi/mtlo in the same cycle are suppressed.
  - An in-flight operation is not aborted; it commits normally.
- When undefined, the Req port is absent and behaves as if Req were tied to 0.

Test Plan:
- Reset, then MDUOp=0 -> HI=LO=0, Busy=0, Start=0, Out=0.
- mult A=0xFFFFFFFE(-2), B=3 -> Start=1 in cycle 0; Busy=1 for cycles 1-5; cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9(-7), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7, B=0 -> HI/LO unchanged after 10 busy cycles.
- mtlo A=0x12345678, next cycle mflo -> Out=0x12345678. During a busy mult, issue mthi A=0xDEADBEEF -> ignored; HI equals the mult result after commit.
- Start div, assert reset at busy cycle 4 -> Busy=0 next cycle, HI=LO=0, no later commit. Also: mult issued while Busy=1 -> Start=0, no restart.
- MDU_CANCEL_EN: mult with Req=1 -> Start=0, no Busy. mthi with Req=1 -> HI unchanged.
